// File: rtl/circuit_vector_sequencer_pkg.sv
// Shared types and sizing helpers for the circuit vector sequencer.
// Engine state encoding and chunk-count arithmetic live here.
package circuit_seq_pkg;

  typedef enum logic [1:0] {
    ENG_IDLE   = 2'd0,
    ENG_SETTLE = 2'd1,
    ENG_RESP   = 2'd2
  } eng_state_e;

  function automatic int num_chunks(input int n_in, input int chunk);
    return (n_in + chunk - 1) / chunk;
  endfunction

  // Keeps index registers at least one bit wide when a vector fits in one chunk.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_CHUNKS = num_chunks(130, 16);
  localparam int CIDX_W     = $clog2(NUM_CHUNKS);

endpackage

// File: rtl/circuit_vector_sequencer_if.sv
// Chunk input stream and result stream of the circuit vector sequencer.
// Handshake: a beat transfers on a rising edge where valid && ready; the source
// holds valid and its payload stable until that edge, and ready may not depend on valid.
interface circuit_vector_sequencer_if #(
  parameter int CHUNK = 16,
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [CHUNK-1:0] in_data;
  logic             res_valid;
  logic             res_ready;
  logic             res_f;
  logic [CNT_W-1:0] res_idx;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_f, res_idx
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_f, res_idx
  );

endinterface

// File: rtl/circuit_vector_sequencer_loader.sv
// Assembles chunks into the shadow vector; the engine's consume strobe
// frees the shadow once it has been copied to the applied register.
module circuit_chunk_loader
  import circuit_seq_pkg::*;
#(
  parameter int N_IN  = 130,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CHUNK-1:0] in_data,
  output logic             in_ready,
  input  logic             consume,
  output logic [N_IN-1:0]  shadow,
  output logic             shadow_full
);

  localparam int NC = num_chunks(N_IN, CHUNK);
  localparam int CW = idx_width(NC);
  localparam logic [CW-1:0] LAST_IDX = CW'(NC - 1);

  logic [CW-1:0]   cidx;
  logic            accept;
  logic [N_IN-1:0] shadow_nxt;

  assign in_ready = !shadow_full;
  assign accept   = in_valid && !shadow_full;

  // Bit-wise merge so last-chunk bits beyond N_IN simply have no destination.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < N_IN; i++) begin
      if (cidx == CW'(i / CHUNK)) shadow_nxt[i] = in_data[i % CHUNK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cidx        <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (consume) shadow_full <= 1'b0;
      if (accept) begin
        shadow <= shadow_nxt;
        if (cidx == LAST_IDX) begin
          cidx        <= '0;
          shadow_full <= 1'b1;
        end else begin
          cidx <= cidx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/circuit_vector_sequencer.sv
// Applies staged vectors to the circuit under test, waits a settle window,
// captures f and returns it with the vector index; keeps vector and hit counts.
module circuit_vector_sequencer
  import circuit_seq_pkg::*;
#(
  parameter int N_IN   = 130,
  parameter int CHUNK  = 16,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  circuit_vector_sequencer_if.slave  bus,
  output logic [N_IN-1:0]            dut_a,
  input  logic                       dut_f,
  input  logic                       clear,
  output logic [CNT_W-1:0]           vec_count,
  output logic [CNT_W-1:0]           hit_count,
  output logic [1:0]                 dbg_state
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);

  localparam logic [1:0] ST_IDLE   = ENG_IDLE;
  localparam logic [1:0] ST_SETTLE = ENG_SETTLE;
  localparam logic [1:0] ST_RESP   = ENG_RESP;

  logic [1:0]      state;
  logic [SW-1:0]   settle_cnt;
  logic [N_IN-1:0] shadow;
  logic            shadow_full;
  logic            consume;
  logic            capture;
  logic            ld_ready;

  assign consume     = (state == ST_IDLE) && shadow_full;
  assign capture     = (state == ST_SETTLE) && (settle_cnt == '0);
  assign dbg_state   = state;
  assign bus.in_ready = ld_ready;

  circuit_chunk_loader #(
    .N_IN  (N_IN),
    .CHUNK (CHUNK)
  ) u_loader (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (bus.in_valid),
    .in_data     (bus.in_data),
    .in_ready    (ld_ready),
    .consume     (consume),
    .shadow      (shadow),
    .shadow_full (shadow_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      dut_a         <= '0;
      settle_cnt    <= '0;
      bus.res_valid <= 1'b0;
      bus.res_f     <= 1'b0;
      bus.res_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (shadow_full) begin
            dut_a      <= shadow;
            settle_cnt <= SETTLE_INIT;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else begin
            bus.res_f     <= dut_f;
            bus.res_idx   <= vec_count;
            bus.res_valid <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Returning to IDLE here delays any pending apply by one edge.
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A clear in the capture cycle wins: that capture is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_count <= '0;
      hit_count <= '0;
    end else if (clear) begin
      vec_count <= '0;
      hit_count <= '0;
    end else if (capture) begin
      vec_count <= vec_count + 1'b1;
      if (dut_f && (hit_count != '1)) hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_circuit_vector_sequencer.sv
// Directed bench for circuit_vector_sequencer with a parity stub as the circuit;
// a CNT_W=4 twin shares the stimulus to exercise counter wrap and saturation.
module tb_circuit_vector_sequencer;

  localparam int N_IN  = 130;
  localparam int CHUNK = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic [N_IN-1:0] dut_a, sat_a;
  logic            dut_f, sat_f;
  logic [15:0]     vec_count, hit_count;
  logic [3:0]      sat_vec, sat_hit;
  logic [1:0]      dbg_state, sat_state;
  int              n_checks = 0;
  int              n_pass   = 0;

  circuit_vector_sequencer_if #(.CHUNK(CHUNK), .CNT_W(16)) bus ();
  circuit_vector_sequencer_if #(.CHUNK(CHUNK), .CNT_W(4))  sbus ();

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign dut_f          = ^dut_a;
  assign sat_f          = ^sat_a;
  assign sbus.in_valid  = bus.in_valid;
  assign sbus.in_data   = bus.in_data;
  assign sbus.res_ready = bus.res_ready;

  circuit_vector_sequencer #(.N_IN(N_IN), .CHUNK(CHUNK), .SETTLE(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .dut_a(dut_a), .dut_f(dut_f), .clear(clear),
    .vec_count(vec_count), .hit_count(hit_count), .dbg_state(dbg_state)
  );

  circuit_vector_sequencer #(.N_IN(N_IN), .CHUNK(CHUNK), .SETTLE(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .bus(sbus), .dut_a(sat_a), .dut_f(sat_f), .clear(clear),
    .vec_count(sat_vec), .hit_count(sat_hit), .dbg_state(sat_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [CHUNK-1:0] d);
    int budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && budget < 40) begin
      tick();
      budget++;
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL chunk_ready_timeout in_ready=%0b exp 1", bus.in_ready);
    else n_pass++;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vector(input logic [143:0] v);
    for (int k = 0; k < 9; k++) send_chunk(v[k*16 +: 16]);
  endtask

  task automatic wait_result();
    int budget = 0;
    while (!bus.res_valid && budget < 40) begin
      tick();
      budget++;
    end
    n_checks++;
    if (bus.res_valid !== 1'b1) $display("FAIL result_timeout res_valid=%0b exp 1", bus.res_valid);
    else n_pass++;
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); else n_pass++;
    n_checks++; if (dut_a !== '0) $display("FAIL reset_dut_a got %h exp 0", dut_a); else n_pass++;
    n_checks++; if ({bus.res_valid, bus.res_f} !== 2'b00) $display("FAIL reset_res got %b exp 00", {bus.res_valid, bus.res_f}); else n_pass++;
    n_checks++; if (bus.res_idx !== 16'd0) $display("FAIL reset_res_idx got %0d exp 0", bus.res_idx); else n_pass++;
    n_checks++; if ({vec_count, hit_count} !== 32'd0) $display("FAIL reset_counts got %h exp 0", {vec_count, hit_count}); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", dbg_state); else n_pass++;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    tick();
  endtask

  task automatic test_single();
    send_vector(144'h0001);
    n_checks++; if (dut_a !== '0) $display("FAIL single_pre_apply got %h exp 0", dut_a); else n_pass++;
    tick();
    n_checks++; if (dut_a !== 130'h1) $display("FAIL single_dut_a got %h exp 1", dut_a); else n_pass++;
    n_checks++; if (dbg_state !== 2'd1) $display("FAIL single_state got %0d exp 1", dbg_state); else n_pass++;
    tick();
    tick();
    n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL single_early_valid got %0b exp 0", bus.res_valid); else n_pass++;
    tick();
    n_checks++; if (bus.res_valid !== 1'b1) $display("FAIL single_capture_edge got %0b exp 1", bus.res_valid); else n_pass++;
    n_checks++; if (bus.res_f !== 1'b1) $display("FAIL single_res_f got %0b exp 1", bus.res_f); else n_pass++;
    n_checks++; if (bus.res_idx !== 16'd0) $display("FAIL single_res_idx got %0d exp 0", bus.res_idx); else n_pass++;
    n_checks++; if (vec_count !== 16'd1 || hit_count !== 16'd1) $display("FAIL single_counts got %0d/%0d exp 1/1", vec_count, hit_count); else n_pass++;
    tick();
    n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL single_consumed got %0b exp 0", bus.res_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    bus.res_ready = 1'b0;
    send_vector(144'h0003);
    wait_result();
    n_checks++; if (bus.res_f !== 1'b0 || bus.res_idx !== 16'd1) $display("FAIL bp_first_res got f=%0b idx=%0d exp f=0 idx=1", bus.res_f, bus.res_idx); else n_pass++;
    send_vector(144'h1 << 16);
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_full got %0b exp 0", bus.in_ready); else n_pass++;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({bus.res_valid, bus.res_f, bus.res_idx, bus.in_ready} !== {1'b1, 1'b0, 16'd1, 1'b0} || dut_a !== 130'h3) begin
        $display("FAIL bp_hold cycle %0d got v=%0b f=%0b idx=%0d rdy=%0b a=%h exp v=1 f=0 idx=1 rdy=0 a=3",
                 c, bus.res_valid, bus.res_f, bus.res_idx, bus.in_ready, dut_a);
        bad++;
      end else n_pass++;
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    n_checks++; if (bus.res_valid !== 1'b0 || dut_a !== 130'h3) $display("FAIL bp_handshake got v=%0b a=%h exp v=0 a=3", bus.res_valid, dut_a); else n_pass++;
    tick();
    n_checks++; if (dut_a !== (130'h1 << 16)) $display("FAIL bp_second_apply got %h exp %h", dut_a, 130'h1 << 16); else n_pass++;
    wait_result();
    n_checks++; if (bus.res_f !== 1'b1 || bus.res_idx !== 16'd2) $display("FAIL bp_second_res got f=%0b idx=%0d exp f=1 idx=2", bus.res_f, bus.res_idx); else n_pass++;
    n_checks++; if (vec_count !== 16'd3 || hit_count !== 16'd2) $display("FAIL bp_counts got %0d/%0d exp 3/2", vec_count, hit_count); else n_pass++;
    tick();
  endtask

  task automatic test_width_wrap();
    logic [143:0] v;
    logic [N_IN-1:0] exp_a;
    v = '0;
    v[15:0] = 16'h0004;
    v[143:128] = 16'hFFFF;
    exp_a = {2'b11, 128'h4};
    send_vector(v);
    wait_result();
    n_checks++; if (dut_a !== exp_a) $display("FAIL wrap_dut_a got %h exp %h", dut_a, exp_a); else n_pass++;
    n_checks++; if (bus.res_f !== ^exp_a) $display("FAIL wrap_res_f got %0b exp %0b", bus.res_f, ^exp_a); else n_pass++;
    n_checks++; if (bus.res_idx !== 16'd3 || vec_count !== 16'd4 || hit_count !== 16'd3) $display("FAIL wrap_counts got idx=%0d %0d/%0d exp 3 4/3", bus.res_idx, vec_count, hit_count); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < 4; k++) send_chunk(16'hAAAA);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1 || dut_a !== '0) $display("FAIL rst_mid_ready_a got rdy=%0b a=%h exp 1 0", bus.in_ready, dut_a); else n_pass++;
    n_checks++; if ({bus.res_valid, bus.res_f, bus.res_idx} !== 18'd0) $display("FAIL rst_mid_res got %h exp 0", {bus.res_valid, bus.res_f, bus.res_idx}); else n_pass++;
    n_checks++; if ({vec_count, hit_count, dbg_state} !== 34'd0) $display("FAIL rst_mid_counts got %h exp 0", {vec_count, hit_count, dbg_state}); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    send_vector(144'h8000);
    wait_result();
    n_checks++; if (dut_a !== 130'h8000) $display("FAIL rst_fresh_dut_a got %h exp 8000", dut_a); else n_pass++;
    n_checks++; if (bus.res_f !== 1'b1 || bus.res_idx !== 16'd0) $display("FAIL rst_fresh_res got f=%0b idx=%0d exp 1 0", bus.res_f, bus.res_idx); else n_pass++;
    n_checks++; if (vec_count !== 16'd1 || hit_count !== 16'd1) $display("FAIL rst_fresh_counts got %0d/%0d exp 1/1", vec_count, hit_count); else n_pass++;
    tick();
  endtask

  task automatic test_clear_collision();
    send_vector(144'h0007);
    tick();
    n_checks++; if (dut_a !== 130'h7) $display("FAIL clr_apply got %h exp 7", dut_a); else n_pass++;
    tick();
    tick();
    n_checks++; if (bus.res_valid !== 1'b0) $display("FAIL clr_pre_capture got %0b exp 0", bus.res_valid); else n_pass++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_f !== 1'b1) $display("FAIL clr_res got v=%0b f=%0b exp 1 1", bus.res_valid, bus.res_f); else n_pass++;
    n_checks++; if (bus.res_idx !== 16'd1) $display("FAIL clr_res_idx got %0d exp 1", bus.res_idx); else n_pass++;
    n_checks++; if (vec_count !== 16'd0 || hit_count !== 16'd0) $display("FAIL clr_counts got %0d/%0d exp 0/0", vec_count, hit_count); else n_pass++;
    tick();
  endtask

  task automatic test_saturation();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (sat_vec !== 4'd0 || sat_hit !== 4'd0) $display("FAIL sat_cleared got %0d/%0d exp 0/0", sat_vec, sat_hit); else n_pass++;
    for (int n = 0; n < 20; n++) begin
      send_vector(144'h0001);
      wait_result();
      tick();
    end
    n_checks++; if (sat_hit !== 4'hF) $display("FAIL sat_hit got %h exp f", sat_hit); else n_pass++;
    n_checks++; if (sat_vec !== 4'd4) $display("FAIL sat_vec_wrap got %0d exp 4", sat_vec); else n_pass++;
    n_checks++; if (sbus.res_idx !== 4'd3) $display("FAIL sat_res_idx got %0d exp 3", sbus.res_idx); else n_pass++;
    n_checks++; if (vec_count !== 16'd20 || hit_count !== 16'd20) $display("FAIL wide_counts got %0d/%0d exp 20/20", vec_count, hit_count); else n_pass++;
    n_checks++; if (bus.res_idx !== 16'd19) $display("FAIL wide_res_idx got %0d exp 19", bus.res_idx); else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_width_wrap();
    test_reset_mid_load();
    test_clear_collision();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
